// File: rtl/cork_supply_ctrl.sv
// cork_supply_ctrl
//   Keeps the capping-line cork tray topped up from a dispenser with limited
//   stock. A four-state FSM (IDLE/MONITOR/DISPENSE/ALARM) watches the tray
//   level, runs a fixed-length dispense when the tray runs low, and raises an
//   alarm when both the tray and the dispenser are empty.
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   enable              line running
//   cork_used           1-cycle pulse, one cork consumed from the tray
//   stock_load          1-cycle pulse, dispenser restocked to STOCK_INIT
//   tray_count          corks in tray (registered)
//   stock_count         corks in dispenser (registered)
//   tray_tens/units     registered BCD digits of tray_count
//   tray_low/empty      zero-latency decodes of tray_count
//   AD / A              dispenser active / alarm, decoded from state
//   refill_done         1-cycle pulse, concurrent with the refilled tray_count
//   underrun            1-cycle pulse, cork_used seen while the tray was empty
module cork_supply_ctrl #(
  parameter int W          = 8,
  parameter int TRAY_CAP   = 20,
  parameter int LOW_THRESH = 5,
  parameter int REFILL_QTY = 15,
  parameter int STOCK_INIT = 40,
  parameter int DISP_LAT   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         cork_used,
  input  logic         stock_load,
  output logic [W-1:0] tray_count,
  output logic [W-1:0] stock_count,
  output logic [3:0]   tray_tens,
  output logic [3:0]   tray_units,
  output logic         tray_low,
  output logic         tray_empty,
  output logic         AD,
  output logic         A,
  output logic         refill_done,
  output logic         underrun
);

  localparam int TW = $clog2(DISP_LAT + 1);

  typedef enum logic [1:0] {IDLE, MONITOR, DISPENSE, ALARM} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [W-1:0]  tray_nxt, stock_nxt;
  logic [W-1:0]  room, xfer;
  logic          refill_nxt, underrun_nxt;

  assign tray_low   = (tray_count <= W'(LOW_THRESH));
  assign tray_empty = (tray_count == '0);
  assign AD         = (state == DISPENSE);
  assign A          = (state == ALARM);

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    tray_nxt     = tray_count;
    stock_nxt    = stock_count;
    refill_nxt   = 1'b0;
    underrun_nxt = 1'b0;

    // Transfer size is taken from the pre-decrement tray level, so a cork
    // used on the transfer cycle still lands the tray at count + T - 1.
    room = W'(TRAY_CAP) - tray_count;
    xfer = W'(REFILL_QTY);
    if (stock_count < xfer) xfer = stock_count;
    if (room < xfer)        xfer = room;

    // Cork consumption; never wraps below zero.
    if (cork_used && state != IDLE) begin
      if (tray_count == '0)    underrun_nxt = 1'b1;
      else if (state != ALARM) tray_nxt     = tray_count - W'(1);
    end

    case (state)
      IDLE: begin
        if (stock_load) stock_nxt = W'(STOCK_INIT);
        if (enable)     state_nxt = MONITOR;
      end
      MONITOR: begin
        if (stock_load) stock_nxt = W'(STOCK_INIT);
        if (!enable)
          state_nxt = IDLE;
        else if (tray_count == '0 && stock_count == '0)
          state_nxt = ALARM;
        else if (tray_count <= W'(LOW_THRESH) && stock_count != '0) begin
          state_nxt = DISPENSE;
          timer_nxt = TW'(DISP_LAT);
        end
      end
      DISPENSE: begin
        // stock_load is deliberately ignored while the dispenser is moving.
        if (!enable)
          state_nxt = IDLE;
        else if (timer == TW'(1)) begin
          tray_nxt   = tray_nxt + xfer;
          stock_nxt  = stock_count - xfer;
          refill_nxt = 1'b1;
          state_nxt  = MONITOR;
        end else
          timer_nxt = timer - TW'(1);
      end
      ALARM: begin
        // Dropping enable wins over a coincident restock.
        if (!enable)
          state_nxt = IDLE;
        else if (stock_load) begin
          stock_nxt = W'(STOCK_INIT);
          state_nxt = MONITOR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      tray_count  <= W'(TRAY_CAP);
      tray_tens   <= 4'(TRAY_CAP / 10);
      tray_units  <= 4'(TRAY_CAP % 10);
      stock_count <= W'(STOCK_INIT);
      refill_done <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      tray_count  <= tray_nxt;
      tray_tens   <= 4'(tray_nxt / W'(10));
      tray_units  <= 4'(tray_nxt % W'(10));
      stock_count <= stock_nxt;
      refill_done <= refill_nxt;
      underrun    <= underrun_nxt;
    end
  end

endmodule
